// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Tracks the instructions in EX, MEM and WB. Drives the EX operand mux
// selects. Raises a one-cycle stall when an instruction in ID uses the
// result of a load that is still in EX. Counts stall cycles (saturating).
//
// Ports
//   i_clk            clock, rising edge
//   i_reset          synchronous active-high reset
//   i_id_valid       ID holds a real instruction
//   i_id_rs1/rs2/rd  register fields of the ID instruction
//   i_id_reg_write   ID instruction writes rd
//   i_id_mem_read    ID instruction is a load
//   i_flush          taken branch/jump, kills the ID instruction
//   o_stall_out      hold PC and IF/ID this cycle
//   o_fwd_a_sel      EX operand A select (00 ID/EX, 01 WB, 10 EX/MEM)
//   o_fwd_b_sel      EX operand B select (same encoding)
//   o_stall_count    saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    input  logic              i_flush,
    output logic              o_stall_out,
    output logic [1:0]        o_fwd_a_sel,
    output logic [1:0]        o_fwd_b_sel,
    output logic [CNT_W-1:0]  o_stall_count
);

    localparam logic [1:0] SEL_IDEX  = 2'b00;
    localparam logic [1:0] SEL_WB    = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;

    logic              r_mem_valid;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_reg_write;
    logic              r_mem_mem_read;

    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_reg_write;

    logic [CNT_W-1:0]  r_stall_count;

    logic              w_mem_writes;
    logic              w_wb_writes;
    logic              w_load_use;
    logic              w_stall;
    logic              w_bubble;
    logic              w_mem_load_hits_ex;

    // x0 is hardwired to zero, so a write to it never forwards.
    assign w_mem_writes = r_mem_valid && r_mem_reg_write && (r_mem_rd != '0);
    assign w_wb_writes  = r_wb_valid  && r_wb_reg_write  && (r_wb_rd  != '0);

    assign w_load_use = r_ex_valid && r_ex_mem_read && r_ex_reg_write &&
                        (r_ex_rd != '0) && i_id_valid &&
                        ((r_ex_rd == i_id_rs1) || (r_ex_rd == i_id_rs2));

    // A flushed ID instruction is discarded anyway, so stalling it is pointless.
    assign w_stall  = w_load_use && !i_flush;
    assign w_bubble = w_stall || i_flush || !i_id_valid;

    // MEM is checked first: it holds the younger of two writes to the same register.
    always_comb begin
        o_fwd_a_sel = SEL_IDEX;
        o_fwd_b_sel = SEL_IDEX;
        if (r_ex_valid) begin
            if (w_mem_writes && (r_mem_rd == r_ex_rs1)) begin
                o_fwd_a_sel = SEL_EXMEM;
            end else if (w_wb_writes && (r_wb_rd == r_ex_rs1)) begin
                o_fwd_a_sel = SEL_WB;
            end
            if (w_mem_writes && (r_mem_rd == r_ex_rs2)) begin
                o_fwd_b_sel = SEL_EXMEM;
            end else if (w_wb_writes && (r_wb_rd == r_ex_rs2)) begin
                o_fwd_b_sel = SEL_WB;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ex_valid      <= 1'b0;
            r_ex_rs1        <= '0;
            r_ex_rs2        <= '0;
            r_ex_rd         <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
            r_stall_count   <= '0;
        end else begin
            r_wb_valid      <= r_mem_valid;
            r_wb_rd         <= r_mem_rd;
            r_wb_reg_write  <= r_mem_reg_write;
            r_mem_valid     <= r_ex_valid;
            r_mem_rd        <= r_ex_rd;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem_read  <= r_ex_mem_read;
            if (w_bubble) begin
                r_ex_valid     <= 1'b0;
                r_ex_rs1       <= '0;
                r_ex_rs2       <= '0;
                r_ex_rd        <= '0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
            end else begin
                r_ex_valid     <= 1'b1;
                r_ex_rs1       <= i_id_rs1;
                r_ex_rs2       <= i_id_rs2;
                r_ex_rd        <= i_id_rd;
                r_ex_reg_write <= i_id_reg_write;
                r_ex_mem_read  <= i_id_mem_read;
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_stall_out   = w_stall;
    assign o_stall_count = r_stall_count;

    // The load-use stall guarantees a load in MEM never feeds the EX sources;
    // forwarding its (address) ALU result would be wrong data.
    assign w_mem_load_hits_ex = r_mem_valid && r_mem_mem_read && w_mem_writes &&
                                r_ex_valid &&
                                ((r_mem_rd == r_ex_rs1) || (r_mem_rd == r_ex_rs2));

    always @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!w_mem_load_hits_ex);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_id_valid;
    logic [AW-1:0] i_id_rs1, i_id_rs2, i_id_rd;
    logic          i_id_reg_write, i_id_mem_read, i_flush;
    logic          o_stall_out;
    logic [1:0]    o_fwd_a_sel, o_fwd_b_sel;
    logic [CW-1:0] o_stall_count;

    int errors = 0;
    int checks = 0;

    fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_id_valid     (i_id_valid),
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_rd        (i_id_rd),
        .i_id_reg_write (i_id_reg_write),
        .i_id_mem_read  (i_id_mem_read),
        .i_flush        (i_flush),
        .o_stall_out    (o_stall_out),
        .o_fwd_a_sel    (o_fwd_a_sel),
        .o_fwd_b_sel    (o_fwd_b_sel),
        .o_stall_count  (o_stall_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // pipe[0] = instruction in EX, pipe[1] = MEM, pipe[2] = WB
    typedef struct {
        logic          v;
        logic [AW-1:0] rs1, rs2, rd;
        logic          rw, mr;
    } ins_t;

    ins_t          pipe [3];
    logic [CW-1:0] m_cnt;
    logic          m_valid = 1'b0;

    // Nearest older instruction that writes r decides where the operand comes from.
    function automatic logic [1:0] m_sel(input logic [AW-1:0] r);
        if (!pipe[0].v) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == r)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        logic lu;
        lu = pipe[0].v && pipe[0].mr && pipe[0].rw && pipe[0].rd != 0 && i_id_valid &&
             (pipe[0].rd == i_id_rs1 || pipe[0].rd == i_id_rs2);
        return lu && !i_flush;
    endfunction

    always @(posedge clk) begin
        ins_t nw;
        logic s;
        if (i_reset) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
            m_cnt   = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            s = m_stall();
            if (s && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
            if (s || i_flush || !i_id_valid) nw = '{default: '0};
            else nw = '{v: 1'b1, rs1: i_id_rs1, rs2: i_id_rs2, rd: i_id_rd,
                        rw: i_id_reg_write, mr: i_id_mem_read};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nw;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_stall", int'(o_stall_out), int'(m_stall()));
            chk("model_sel_a", int'(o_fwd_a_sel), int'(m_sel(pipe[0].rs1)));
            chk("model_sel_b", int'(o_fwd_b_sel), int'(m_sel(pipe[0].rs2)));
            chk("model_count", int'(o_stall_count), int'(m_cnt));
            if (pipe[1].v && pipe[1].mr && pipe[1].rw && pipe[1].rd != 0 && pipe[0].v &&
                (pipe[1].rd == pipe[0].rs1 || pipe[1].rd == pipe[0].rs2)) begin
                errors++;
                $display("FAIL load_in_mem_feeds_ex: got 1 expected 0 at %0t", $time);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rw, input logic mr,
                       input logic fl);
        @(posedge clk);
        #1;
        i_id_valid = v; i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_rd = rd;
        i_id_reg_write = rw; i_id_mem_read = mr; i_flush = fl;
        @(negedge clk);
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) nop();
    endtask

    int c0;

    initial begin
        i_reset = 1'b1;
        i_id_valid = 0; i_id_rs1 = 0; i_id_rs2 = 0; i_id_rd = 0;
        i_id_reg_write = 0; i_id_mem_read = 0; i_flush = 0;
        nop(); nop();
        chk("reset_stall", int'(o_stall_out), 0);
        chk("reset_sel_a", int'(o_fwd_a_sel), 0);
        chk("reset_sel_b", int'(o_fwd_b_sel), 0);
        chk("reset_count", int'(o_stall_count), 0);
        @(posedge clk); #1; i_reset = 1'b0;

        // back-to-back ALU dependency
        cyc(1, 1, 2, 5, 1, 0, 0);
        cyc(1, 5, 5, 6, 1, 0, 0);
        chk("b2b_stall", int'(o_stall_out), 0);
        nop();
        chk("b2b_sel_a", int'(o_fwd_a_sel), 2);
        chk("b2b_sel_b", int'(o_fwd_b_sel), 2);
        drain();

        // distance-2 dependency on rs2
        cyc(1, 0, 0, 7, 1, 0, 0);
        cyc(1, 1, 2, 8, 1, 0, 0);
        cyc(1, 9, 7, 10, 1, 0, 0);
        nop();
        chk("dist2_sel_a", int'(o_fwd_a_sel), 0);
        chk("dist2_sel_b", int'(o_fwd_b_sel), 1);
        drain();

        // double write: younger write wins
        cyc(1, 1, 0, 3, 1, 0, 0);
        cyc(1, 1, 0, 3, 1, 0, 0);
        cyc(1, 3, 3, 11, 1, 0, 0);
        nop();
        chk("dbl_sel_a", int'(o_fwd_a_sel), 2);
        chk("dbl_sel_b", int'(o_fwd_b_sel), 2);
        drain();

        // load-use
        c0 = int'(o_stall_count);
        cyc(1, 1, 0, 4, 1, 1, 0);
        cyc(1, 4, 2, 12, 1, 0, 0);
        chk("lu_stall_n", int'(o_stall_out), 1);
        cyc(1, 4, 2, 12, 1, 0, 0);
        chk("lu_stall_n1", int'(o_stall_out), 0);
        chk("lu_bubble_a", int'(o_fwd_a_sel), 0);
        chk("lu_count_n1", int'(o_stall_count), c0 + 1);
        nop();
        chk("lu_sel_a", int'(o_fwd_a_sel), 1);
        chk("lu_sel_b", int'(o_fwd_b_sel), 0);
        chk("lu_count", int'(o_stall_count), c0 + 1);
        drain();

        // x0 never forwards, a load to x0 never stalls
        cyc(1, 1, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 13, 1, 0, 0);
        nop();
        chk("x0_sel_a", int'(o_fwd_a_sel), 0);
        chk("x0_sel_b", int'(o_fwd_b_sel), 0);
        drain();
        cyc(1, 1, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 14, 1, 0, 0);
        chk("x0_load_stall", int'(o_stall_out), 0);
        drain();

        // load-use killed by flush
        c0 = int'(o_stall_count);
        cyc(1, 1, 0, 4, 1, 1, 0);
        cyc(1, 4, 4, 15, 1, 0, 1);
        chk("flush_stall", int'(o_stall_out), 0);
        nop();
        chk("flush_count", int'(o_stall_count), c0);
        chk("flush_bubble_b", int'(o_fwd_b_sel), 0);
        drain();

        // saturation
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 0, 4, 1, 1, 0);
            cyc(1, 2, 4, 16, 1, 0, 0);
            chk("sat_loop_stall", int'(o_stall_out), 1);
            cyc(1, 2, 4, 16, 1, 0, 0);
        end
        nop();
        chk("sat_count", int'(o_stall_count), int'(CMAX));
        cyc(1, 1, 0, 4, 1, 1, 0);
        cyc(1, 4, 0, 17, 1, 0, 0);
        chk("sat_stall", int'(o_stall_out), 1);
        nop();
        chk("sat_hold", int'(o_stall_count), int'(CMAX));
        drain();

        // reset mid-stall
        cyc(1, 1, 0, 4, 1, 1, 0);
        cyc(1, 4, 0, 18, 1, 0, 0);
        chk("rst_pre_stall", int'(o_stall_out), 1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", int'(o_stall_out), 0);
        chk("rst_sel_a", int'(o_fwd_a_sel), 0);
        chk("rst_sel_b", int'(o_fwd_b_sel), 0);
        chk("rst_count", int'(o_stall_count), 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the 5-stage pipeline. It tracks the destination and source registers of the instructions in EX, MEM and WB, and drives the 2-bit select inputs of the two EX-stage operand 3-to-1 muxes. It also raises a one-cycle stall on load-use dependencies and counts stall cycles for performance monitoring. It sits beside the ID/EX pipeline register and receives the decoded fields of the instruction currently in ID.

## Interface
- REG_AW, default 5: register address width.
- CNT_W, default 32: width of the stall counter.

- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- id_valid, input, 1: ID holds a real instruction.
- id_rs1, input, REG_AW: rs1 of the ID instruction.
- id_rs2, input, REG_AW: rs2 of the ID instruction.
- id_rd, input, REG_AW: rd of the ID instruction.
- id_reg_write, input, 1: the ID instruction writes rd.
- id_mem_read, input, 1: the ID instruction is a load.
- flush, input, 1: taken branch or jump; kills the ID instruction.
- stall_out, output, 1: hold PC and IF/ID this cycle.
- fwd_a_sel, output, 2: mux select for EX operand A.
- fwd_b_sel, output, 2: mux select for EX operand B.
- stall_count, output, CNT_W: saturating count of stall cycles.

## Operation
- **Select encoding:** 2'b00 is the ID/EX register value, 2'b01 is the WB-stage result, 2'b10 is the EX/MEM ALU result. 2'b11 is never driven.
- **Internal tracking registers:**
  - EX slot: valid, rs1, rs2, rd, reg_write, mem_read.
  - MEM slot: valid, rd, reg_write, mem_read.
  - WB slot: valid, rd, reg_write.
- **Slot advance, every cycle:** WB takes MEM, MEM takes EX, EX takes the ID fields.
- **Bubble insertion:** EX loads a bubble (all fields 0) when any of the following holds:
  - stall_out = 1,
  - flush = 1,
  - id_valid = 0.
- **Producer condition:** a slot "produces r" when valid && reg_write && rd != 0 && rd == r.
- **Forwarding for operand A:**
  - MEM produces EX.rs1 → 2'b10.
  - Otherwise WB produces EX.rs1 → 2'b01.
  - Otherwise → 2'b00.
  - MEM has priority over WB because it is the younger write.
- **Forwarding for operand B:** same rules using EX.rs2.
- **Invalid EX slot:** both selects are 2'b00.
- **Load-use hazard (load_use):** all of the following hold:
  - EX.valid && EX.mem_read && EX.reg_write && EX.rd != 0,
  - id_valid,
  - EX.rd == id_rs1 or EX.rd == id_rs2.
- **Stall output:** stall_out = load_use && !flush. A flushed ID instruction never stalls.
- **Register-file hazard:** a WB write and an ID read of the same register in the same cycle is handled by the register file (write-before-read). It is not a hazard for this block.
- **stall_count:**
  - Increments by 1 on every rising edge where stall_out = 1.
  - Holds at all-ones (saturates).
- **Reset:**
  - All slot valid bits and fields clear to 0.
  - stall_count = 0.
  - Outputs: fwd_a_sel = 2'b00, fwd_b_sel = 2'b00, stall_out = 0.

## Timing
- fwd_a_sel, fwd_b_sel and stall_out are combinational from slot registers and current inputs.
- Selects are valid in the same cycle the consumer occupies EX (zero latency).
- Load-use costs exactly one stall cycle:
  - Cycle n: load in EX, consumer in ID → stall_out = 1.
  - Cycle n+1: load in MEM, bubble in EX.
  - Cycle n+2: load in WB, consumer in EX → select 2'b01.
- By construction, a load in MEM never matches the EX source registers. The bench asserts this never occurs.
- flush and stall in the same cycle: the bubble is inserted, stall_out = 0, stall_count is unchanged.
- reset asserted mid-stall: next cycle all slots are empty, stall_out = 0, stall_count = 0.
- stall_count is registered: the value updates the edge after the stall cycle.

## Test plan
- **Back-to-back ALU dependency:**
  - Stimulus: add x5 in ID at cycle 0, then sub x6, x5, x5 at cycle 1.
  - Response at cycle 2: fwd_a_sel = fwd_b_sel = 2'b10, stall_out = 0.
- **Distance-2 dependency:**
  - Stimulus: write x7, then an unrelated instruction, then a read of x7 as rs2.
  - Response: fwd_b_sel = 2'b01, fwd_a_sel = 2'b00.
- **Double write:**
  - Stimulus: two successive writes to x3, then a read of x3.
  - Response: select 2'b10 (the younger write wins over WB).
- **Load-use:**
  - Stimulus: lw x4, then add using x4.
  - Response: stall_out = 1 for exactly one cycle; bubble observed; consumer sees 2'b01; stall_count = 1.
- **x0 and flush:**
  - Stimulus: write x0 then read x0 → select 2'b00. Separately, load-use with flush = 1 in the same cycle.
  - Response: stall_out = 0, stall_count unchanged.
- **Saturation and reset:**
  - Stimulus: preload the counter to all-ones and force a stall; separately assert reset mid-stall.
  - Response: counter holds at all-ones; after reset, outputs are 0/2'b00 and count = 0.
